int_to_float_seq: RTL and testbench

Multi-cycle Nios II custom-instruction unit that converts a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision float, rounding to nearest, ties to even.
Sequences one instance of the existing combinational leading-zero counter `clz` through absolute-value, normalise and round stages.
Fixed 3-cycle latency.
Sits in the conv custom-instruction group beside the float-to-int and related datapaths.

---
 rtl/int_to_float_seq.sv | 147 ++++++++++++++
 tb/tb_int_to_float_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_seq.sv
// Multi-cycle integer to IEEE-754 single-precision converter (round to nearest, ties to even).
// Nios II custom-instruction unit with a fixed 3-cycle latency: IDLE -> ABS -> NORM -> RND.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   clk_en  clock enable; every register holds while low
//   start   request strobe, accepted only in IDLE
//   dataa   32-bit integer operand, captured on the accepted start edge
//   n       operand type: 0 = signed, 1 = unsigned
//   busy    high while a conversion is in flight (ABS, NORM, RND)
//   done    one-cycle completion pulse
//   result  float result, valid with done and held until the next completion
module int_to_float_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic        n,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StAbs, StNorm, StRnd} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        un_q, un_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  lz_q, lz_d;
  logic [30:0] shifted_q, shifted_d;  // bit 31 is the implicit leading one, never stored
  logic [7:0]  exp_q, exp_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Leading-zero count built from zero tests of 16/8/4/2/1-bit windows.
  // The count for an all-zero input is meaningless and masked by the zero flag.
  function automatic logic [4:0] clz(input logic [31:0] x);
    logic [31:0] v;
    logic [4:0]  c;
    v    = x;
    c[4] = (v[31:16] == 16'd0);
    if (c[4]) v = v << 16;
    c[3] = (v[31:24] == 8'd0);
    if (c[3]) v = v << 8;
    c[2] = (v[31:28] == 4'd0);
    if (c[2]) v = v << 4;
    c[1] = (v[31:30] == 2'd0);
    if (c[1]) v = v << 2;
    c[0] = ~v[31];
    return c;
  endfunction

  // Rounding of the normalised magnitude.
  logic [22:0] mant;
  logic        guard, sticky, rnd_up, carry;
  logic [22:0] mant_r;
  logic [7:0]  exp_r;

  assign mant            = shifted_q[30:8];
  assign guard           = shifted_q[7];
  assign sticky          = |shifted_q[6:0];
  assign rnd_up          = guard & (sticky | mant[0]);
  // A carry out of the mantissa leaves it zero and bumps the exponent.
  assign {carry, mant_r} = {1'b0, mant} + {23'd0, rnd_up};
  assign exp_r           = exp_q + {7'd0, carry};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    un_d      = un_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    lz_d      = lz_q;
    shifted_d = shifted_q;
    exp_d     = exp_q;
    zero_d    = zero_q;
    done_d    = done_q;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (start) begin
          a_d     = dataa;
          un_d    = n;
          state_d = StAbs;
        end
      end
      StAbs: begin
        sign_d  = ~un_q & a_q[31];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
        mag_d   = sign_d ? (32'd0 - a_q) : a_q;
        state_d = StNorm;
      end
      StNorm: begin
        lz_d      = clz(mag_q);
        shifted_d = 31'(mag_q << lz_d);
        exp_d     = 8'd158 - {3'd0, lz_d};
        zero_d    = (mag_q == 32'd0);
        state_d   = StRnd;
      end
      StRnd: begin
        result_d = zero_q ? 32'd0 : {sign_q, exp_r, mant_r};
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= 32'd0;
      un_q      <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      lz_q      <= 5'd0;
      shifted_q <= 31'd0;
      exp_q     <= 8'd0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else if (clk_en) begin
      state_q   <= state_d;
      a_q       <= a_d;
      un_q      <= un_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      lz_q      <= lz_d;
      shifted_q <= shifted_d;
      exp_q     <= exp_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Self-checking bench for int_to_float_seq: a latency-level reference model checked every cycle,
// plus directed vectors with hand-computed float encodings.
module tb_int_to_float_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic        n = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  int_to_float_seq dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference conversion from plain integer arithmetic: locate the top set bit, then round the
  // discarded low part against half an ulp.
  function automatic logic [31:0] ref_float(input logic [31:0] a, input logic un);
    logic            s;
    longint unsigned m, q, rem, half;
    int              p, sh;
    logic [7:0]      e;
    s = !un && a[31];
    m = s ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
    if (m == 0) return 32'd0;
    p = 63;
    while (((m >> p) & 64'd1) == 0) p--;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    e = 8'(127 + p);
    return {s, e, q[22:0]};
  endfunction

  // Latency model: a conversion accepted on an enabled IDLE edge completes 3 enabled edges later.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_a = 32'd0;
  logic        m_un = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    = 0;
      m_done   = 1'b0;
      m_result = 32'd0;
    end else if (clk_en) begin
      if (m_cnt == 0) begin
        m_done = 1'b0;
        if (start) begin
          m_cnt = 3;
          m_a   = dataa;
          m_un  = n;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done   = 1'b1;
          m_result = ref_float(m_a, m_un);
        end
      end
    end
  end

  // Every-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      check("cyc_done", {31'd0, done}, {31'd0, m_done});
      check("cyc_result", result, m_result);
    end
  end

  task automatic run_one(input logic [31:0] a, input logic nn, input logic [31:0] expv,
                         input string name);
    @(negedge clk);
    start = 1'b1;
    dataa = a;
    n     = nn;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check({name, "_early_done"}, {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_result"}, result, expv);
  endtask

  int          ndone;
  logic [31:0] r1, r2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Pin the reference model itself.
    check("model_one", ref_float(32'd1, 1'b0), 32'h3F800000);
    check("model_umax", ref_float(32'hFFFFFFFF, 1'b1), 32'h4F800000);
    check("model_tie_odd", ref_float(32'h01000003, 1'b0), 32'h4B800002);
    check("model_smin", ref_float(32'h80000000, 1'b0), 32'hCF000000);

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_one(32'd1, 1'b0, 32'h3F800000, "one");
    run_one(32'hFFFFFFFF, 1'b0, 32'hBF800000, "minus_one");
    run_one(32'd0, 1'b0, 32'h00000000, "zero");
    run_one(32'h80000000, 1'b0, 32'hCF000000, "smin");
    run_one(32'hFFFFFFFF, 1'b1, 32'h4F800000, "umax");
    run_one(32'h80000000, 1'b1, 32'h4F000000, "u2p31");
    run_one(32'h01000001, 1'b0, 32'h4B800000, "tie_even");
    run_one(32'h01000003, 1'b0, 32'h4B800002, "tie_odd");
    run_one(32'h01000002, 1'b0, 32'h4B800001, "exact");
    run_one(32'h00000000, 1'b1, 32'h00000000, "uzero");

    // start held for 8 edges: accepted at E and at E+4 only.
    ndone = 0;
    r1 = 32'd0;
    r2 = 32'd0;
    @(negedge clk);
    start = 1'b1;
    dataa = 32'd5;
    n     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) r1 = result;
        else r2 = result;
      end
      @(negedge clk);
      if (k == 0) dataa = 32'd7;
      if (k == 7) start = 1'b0;
    end
    check("hs_count", ndone, 32'd2);
    check("hs_first", r1, 32'h40A00000);
    check("hs_second", r2, 32'h40E00000);

    // clk_en low for two edges while in NORM.
    @(negedge clk);
    start = 1'b1;
    dataa = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    check("en_frozen_busy", {31'd0, busy}, 32'd1);
    check("en_frozen_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("en_e4_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("en_e5_done", {31'd0, done}, 32'd1);
    check("en_e5_result", result, 32'h40400000);

    // Asynchronous reset while in RND.
    @(negedge clk);
    start = 1'b1;
    dataa = 32'd100;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_one(32'd100, 1'b0, 32'h42C80000, "after_rst");

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
